// File: rtl/pe_array_ctrl_if.sv
// Bundle of job control, input stream, weight read, array and result signals
// for the PE array sequencer.
interface pe_array_ctrl_if #(
  parameter int unsigned ELEMENT_BITS = 8,
  parameter int unsigned ROW_BITS     = 8
);
  logic                    start;
  logic [ROW_BITS-1:0]     cfg_rows;
  logic                    busy;
  logic                    done;
  logic                    in_valid;
  logic [ELEMENT_BITS-1:0] in_data;
  logic                    in_ready;
  logic                    wgt_rd_en;
  logic [ROW_BITS-1:0]     wgt_rd_addr;
  logic                    pe_step;
  logic [ELEMENT_BITS-1:0] arr_in_data;
  logic [ELEMENT_BITS-1:0] arr_out_data;
  logic                    out_valid;
  logic [ELEMENT_BITS-1:0] out_data;
  logic [ROW_BITS-1:0]     out_row_idx;

  modport master (
    output start, cfg_rows, in_valid, in_data, arr_out_data,
    input  busy, done, in_ready, wgt_rd_en, wgt_rd_addr, pe_step,
           arr_in_data, out_valid, out_data, out_row_idx
  );

  modport slave (
    input  start, cfg_rows, in_valid, in_data, arr_out_data,
    output busy, done, in_ready, wgt_rd_en, wgt_rd_addr, pe_step,
           arr_in_data, out_valid, out_data, out_row_idx
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// Sequencer for a linear PE array: divides sys_clk into array steps, feeds the
// array tail, reads weights per step and registers results leaving the head.
module pe_array_ctrl #(
  parameter int unsigned ELEMENT_BITS = 8,
  parameter int unsigned P            = 4,
  parameter int unsigned PE_DIV       = 4,
  parameter int unsigned ROW_BITS     = 8
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  pe_array_ctrl_if.slave     bus
);
  localparam int unsigned DIV_W = $clog2(PE_DIV);
  localparam int unsigned S_W   = ROW_BITS + $clog2(P) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [S_W-1:0]          s_q, s_d;
  logic [ROW_BITS-1:0]     rows_q, rows_d;
  logic                    out_valid_q, out_valid_d;
  logic [ELEMENT_BITS-1:0] out_data_q, out_data_d;
  logic [ROW_BITS-1:0]     out_idx_q, out_idx_d;

  logic                    step;
  logic                    in_ready;
  logic                    wgt_en;
  logic [ROW_BITS-1:0]     wgt_addr;
  logic [ELEMENT_BITS-1:0] arr_in;
  logic                    div_last;
  logic [S_W-1:0]          rows_ext;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    s_d         = s_q;
    rows_d      = rows_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    step        = 1'b0;
    in_ready    = 1'b0;
    wgt_en      = 1'b0;
    wgt_addr    = '0;
    arr_in      = '0;
    div_last    = (div_q == DIV_W'(PE_DIV - 1));
    rows_ext    = S_W'(rows_q);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rows_d = bus.cfg_rows;
          if (bus.cfg_rows == '0) begin
            state_d = DONE;
          end else begin
            state_d = STREAM;
            div_d   = '0;
            s_d     = '0;
          end
        end
      end
      STREAM, DRAIN: begin
        step = div_last && ((state_q == DRAIN) || bus.in_valid);
        // Divider parks on its last value while the input stream stalls.
        if (!div_last) begin
          div_d = div_q + DIV_W'(1);
        end else if (step) begin
          div_d = '0;
        end
        if (step) begin
          wgt_en   = 1'b1;
          wgt_addr = s_q[ROW_BITS-1:0];
          s_d      = s_q + S_W'(1);
          if (state_q == STREAM) begin
            in_ready = 1'b1;
            arr_in   = bus.in_data;
          end
          if (s_q >= S_W'(P)) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.arr_out_data;
            out_idx_d   = ROW_BITS'(s_q - S_W'(P));
          end
          if ((state_q == STREAM) && (s_q == rows_ext - S_W'(1))) begin
            state_d = DRAIN;
          end
          if ((state_q == DRAIN) && (s_q == rows_ext + S_W'(P) - S_W'(1))) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      s_q         <= '0;
      rows_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      s_q         <= s_d;
      rows_q      <= rows_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.in_ready    = in_ready;
  assign bus.wgt_rd_en   = wgt_en;
  assign bus.wgt_rd_addr = wgt_addr;
  assign bus.pe_step     = step;
  assign bus.arr_in_data = arr_in;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_row_idx = out_idx_q;
endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
- REQ-001: Parameter ELEMENT_BITS, default 8, width of one data/weight element.
- REQ-002: Parameter P, default 4, number of PEs in the sequenced linear array.
- REQ-003: Parameter PE_DIV, default 4, sys_clk cycles per array step; legal range >= 2.
- REQ-004: Parameter ROW_BITS, default 8, width of row count and weight address.
- REQ-005: sys_clk  in  1  single clock; all logic on rising edge.
- REQ-006: reset_n  in  1  reset, synchronous, active-low.
- REQ-007: start  in  1  job request pulse; sampled only in IDLE.
- REQ-008: cfg_rows  in  ROW_BITS  number of stream steps in the job; captured on accepted start.
- REQ-009: busy  out  1  high from the cycle after accepted start through the DONE cycle.
- REQ-010: done  out  1  one-cycle completion pulse.
- REQ-011: in_valid  in  1  input element available.
- REQ-012: in_data  in  ELEMENT_BITS  input vector element.
- REQ-013: in_ready  out  1  element consumed this cycle; equals pe_step while in STREAM.
- REQ-014: wgt_rd_en  out  1  weight word read strobe.
- REQ-015: wgt_rd_addr  out  ROW_BITS  weight word index for the current step.
- REQ-016: pe_step  out  1  one-cycle array advance enable, replaces the slow array clock.
- REQ-017: arr_in_data  out  ELEMENT_BITS  element driven into the array tail.
- REQ-018: arr_out_data  in  ELEMENT_BITS  result leaving the array head.
- REQ-019: out_valid  out  1  result strobe.
- REQ-020: out_data  out  ELEMENT_BITS  registered result.
- REQ-021: out_row_idx  out  ROW_BITS  row index of out_data.

Function
- REQ-022: FSM states IDLE, STREAM, DRAIN, DONE; encoding free.
- REQ-023: IDLE: start=1 and cfg_rows!=0 -> STREAM; start=1 and cfg_rows==0 -> DONE (no pe_step issued).
- REQ-024: start outside IDLE is ignored; cfg_rows changes after capture have no effect.
- REQ-025: Step divider counts 0..PE_DIV-1, cleared on STREAM entry, increments each cycle in STREAM/DRAIN, holds at PE_DIV-1 while stalled.
- REQ-026: pe_step=1 when divider==PE_DIV-1 and (state==DRAIN or in_valid==1); otherwise 0.
- REQ-027: Step counter s counts from 0, increments on each pe_step; width ROW_BITS+log2(P)+1, no wrap.
- REQ-028: STREAM: on pe_step, arr_in_data=in_data, wgt_rd_en=1, wgt_rd_addr=s; in_ready=1 that cycle only.
- REQ-029: STREAM -> DRAIN on the pe_step where s==cfg_rows-1.
- REQ-030: DRAIN: arr_in_data=0, in_ready=0; wgt_rd_en=1 with wgt_rd_addr=s on each pe_step.
- REQ-031: On pe_step with s>=P: register out_data=arr_out_data, out_row_idx=s-P, out_valid=1 the following cycle, one cycle wide.
- REQ-032: DRAIN -> DONE on the pe_step where s==cfg_rows+P-1; total steps per job = cfg_rows+P.
- REQ-033: DONE lasts one cycle with done=1, then IDLE; start in DONE ignored.
- REQ-034: in_valid low at step boundary in STREAM stalls: no pe_step, no wgt_rd_en, counters hold, unbounded.
- REQ-035: Outside STREAM/DRAIN: pe_step, wgt_rd_en, in_ready all 0; arr_in_data=0.

Reset
- REQ-036: reset_n=0 at a rising edge forces IDLE, clears divider and step counter; busy, done, in_ready, wgt_rd_en, pe_step, out_valid=0; arr_in_data, out_data, out_row_idx, wgt_rd_addr=0.
- REQ-037: Reset mid-job aborts without done; next accepted start begins a fresh job.

Verification
- REQ-038: P=4, PE_DIV=4, cfg_rows=3, in_valid=1, start at cycle 0 -> busy from 1; pe_step at 4,8,...,28 (7 steps); out_valid at 21,25,29 with idx 0,1,2; done at 29.
- REQ-039: Same job, in_valid low cycles 6-10 -> step 1 delayed to cycle 11; all later events shift by 3 cycles.
- REQ-040: cfg_rows=0 start -> done=1 at cycle 1, no pe_step/wgt_rd_en/out_valid ever.
- REQ-041: start pulsed during STREAM and during DONE -> ignored; exactly one done per job.
- REQ-042: reset_n low at cycle 10 of REQ-038 job -> all outputs 0 next cycle, IDLE; new start runs full 7-step job.
- REQ-043: arr_out_data=step index+0x10 stimulus -> out_data 0x14,0x15,0x16 paired with idx 0,1,2.
